// File: rtl/pe_bus_pkg.sv
`default_nettype none
// ============================================================================
// pe_bus_pkg : register map, CTRL bit layout and FSM states for pe_bus_sequencer
// Rev 1.0
// ============================================================================
package pe_bus_pkg;

  localparam int unsigned PE_A_ADDR      = 0;
  localparam int unsigned PE_B_ADDR      = 1;
  localparam int unsigned PE_CTRL_ADDR   = 2;
  localparam int unsigned PE_THRESH_ADDR = 3;
  localparam int unsigned PE_DATA_ADDR   = 4;
  localparam int unsigned PE_RECOG_ADDR  = 5;

  localparam int unsigned PE_CTRL_START_BIT  = 0;
  localparam int unsigned PE_CTRL_MODE_BIT   = 1;
  localparam int unsigned PE_CTRL_CLR_BIT    = 2;
  localparam int unsigned PE_CTRL_RELU_BIT   = 3;
  localparam int unsigned PE_CTRL_BITSEL_BIT = 4;
  localparam int unsigned PE_STAT_VLD_BIT    = 8;

  localparam logic [3:0] PE_WEN_BYTE0 = 4'b0001;
  localparam logic [3:0] PE_WEN_LOW24 = 4'b0111;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WR_THR = 4'd1,
    ST_WR_CLR = 4'd2,
    ST_WAIT_OP = 4'd3,
    ST_WR_A   = 4'd4,
    ST_WR_B   = 4'd5,
    ST_WR_GO  = 4'd6,
    ST_GAP    = 4'd7,
    ST_POLL   = 4'd8,
    ST_DRAIN  = 4'd9,
    ST_RD_DAT = 4'd10,
    ST_RD_BIT = 4'd11,
    ST_RESP   = 4'd12
  } pe_seq_state_e;

  function automatic logic [31:0] pe_ctrl_word(input logic start, input logic clr,
                                               input logic mode, input logic relu,
                                               input logic bitsel);
    logic [31:0] w_word;
    w_word                     = '0;
    w_word[PE_CTRL_START_BIT]  = start;
    w_word[PE_CTRL_MODE_BIT]   = mode;
    w_word[PE_CTRL_CLR_BIT]    = clr;
    w_word[PE_CTRL_RELU_BIT]   = relu;
    w_word[PE_CTRL_BITSEL_BIT] = bitsel;
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_bus_sequencer.sv
`default_nettype none
// ============================================================================
// pe_bus_sequencer : runs MAC jobs on the PE through its SRAM-style register window
// Rev 1.0
// ============================================================================
module pe_bus_sequencer
  import pe_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int LEN_W      = 8,
  parameter int POLL_MAX   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [LEN_W-1:0]      cmd_len_i,
  input  logic                  cmd_mode_i,
  input  logic                  cmd_relu_i,
  input  logic                  cmd_bitsel_i,
  input  logic [23:0]           cmd_thresh_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [7:0]            op_a_i,
  input  logic [7:0]            op_b_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [23:0]           res_data_o,
  output logic                  res_bit_o,
  output logic                  res_err_o,
  output logic                  busy_o,
  output logic                  req_o,
  output logic [3:0]            wen_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [31:0]           wdata_o,
  input  logic [31:0]           rdata_i
);

  localparam int PW = $clog2(POLL_MAX + 1);

  pe_seq_state_e         r_state, w_state_nxt;
  logic [LEN_W-1:0]      r_cnt;
  logic [PW-1:0]         r_poll;
  logic                  r_mode, r_relu, r_bitsel;
  logic [7:0]            r_b;
  logic [23:0]           r_data;
  logic                  r_bit, r_err, r_rdy;
  logic                  r_req;
  logic [3:0]            r_wen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;

  logic                  w_req;
  logic [3:0]            w_wen;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_wdata;
  logic                  w_cmd_fire, w_op_fire, w_res_fire;
  logic                  w_vld, w_poll_last, w_unused_rdata;

  assign cmd_ready_o = r_rdy && (r_state == ST_IDLE);
  assign op_ready_o  = (r_state == ST_WAIT_OP) || ((r_state == ST_DRAIN) && (r_cnt != '0));
  assign res_valid_o = (r_state == ST_RESP);
  assign busy_o      = (r_state != ST_IDLE);
  assign res_data_o  = r_data;
  assign res_bit_o   = r_bit;
  assign res_err_o   = r_err;
  assign req_o       = r_req;
  assign wen_o       = r_wen;
  assign addr_o      = r_addr;
  assign wdata_o     = r_wdata;

  assign w_cmd_fire     = cmd_valid_i && cmd_ready_o;
  assign w_op_fire      = op_valid_i && op_ready_o;
  assign w_res_fire     = res_valid_o && res_ready_i;
  assign w_vld          = rdata_i[PE_STAT_VLD_BIT];
  assign w_poll_last    = (r_poll == PW'(POLL_MAX - 1));
  assign w_unused_rdata = ^rdata_i[31:24];

  // Bus fields are decoded for the state being entered so they sit in flops.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_wen       = '0;
    w_addr      = '0;
    w_wdata     = '0;
    unique case (r_state)
      ST_IDLE: if (w_cmd_fire) begin
        w_state_nxt = ST_WR_THR;
        w_req       = 1'b1;
        w_wen       = PE_WEN_LOW24;
        w_addr      = ADDR_WIDTH'(PE_THRESH_ADDR);
        w_wdata     = {8'h00, cmd_thresh_i};
      end
      ST_WR_THR: begin
        w_state_nxt = ST_WR_CLR;
        w_req       = 1'b1;
        w_wen       = PE_WEN_BYTE0;
        w_addr      = ADDR_WIDTH'(PE_CTRL_ADDR);
        w_wdata     = pe_ctrl_word(1'b0, 1'b1, r_mode, r_relu, r_bitsel);
      end
      ST_WR_CLR: begin
        if (r_cnt != '0) begin
          w_state_nxt = ST_WAIT_OP;
        end else begin
          w_state_nxt = ST_RD_DAT;
          w_req       = 1'b1;
          w_addr      = ADDR_WIDTH'(PE_DATA_ADDR);
        end
      end
      ST_WAIT_OP: if (w_op_fire) begin
        w_state_nxt = ST_WR_A;
        w_req       = 1'b1;
        w_wen       = PE_WEN_BYTE0;
        w_addr      = ADDR_WIDTH'(PE_A_ADDR);
        w_wdata     = {24'h0, op_a_i};
      end
      ST_WR_A: begin
        w_state_nxt = ST_WR_B;
        w_req       = 1'b1;
        w_wen       = PE_WEN_BYTE0;
        w_addr      = ADDR_WIDTH'(PE_B_ADDR);
        w_wdata     = {24'h0, r_b};
      end
      ST_WR_B: begin
        w_state_nxt = ST_WR_GO;
        w_req       = 1'b1;
        w_wen       = PE_WEN_BYTE0;
        w_addr      = ADDR_WIDTH'(PE_CTRL_ADDR);
        w_wdata     = pe_ctrl_word(1'b1, 1'b0, r_mode, r_relu, r_bitsel);
      end
      ST_WR_GO: w_state_nxt = ST_GAP;
      ST_GAP: begin
        w_state_nxt = ST_POLL;
        w_req       = 1'b1;
        w_addr      = ADDR_WIDTH'(PE_CTRL_ADDR);
      end
      ST_POLL: begin
        if (w_vld) begin
          if (r_cnt != '0) begin
            w_state_nxt = ST_WAIT_OP;
          end else begin
            w_state_nxt = ST_RD_DAT;
            w_req       = 1'b1;
            w_addr      = ADDR_WIDTH'(PE_DATA_ADDR);
          end
        end else if (w_poll_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_req  = 1'b1;
          w_addr = ADDR_WIDTH'(PE_CTRL_ADDR);
        end
      end
      ST_DRAIN: if (r_cnt == '0) w_state_nxt = ST_RESP;
      ST_RD_DAT: begin
        w_state_nxt = ST_RD_BIT;
        w_req       = 1'b1;
        w_addr      = ADDR_WIDTH'(PE_RECOG_ADDR);
      end
      ST_RD_BIT: w_state_nxt = ST_RESP;
      ST_RESP: if (w_res_fire) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdy    <= 1'b0;
      r_cnt    <= '0;
      r_poll   <= '0;
      r_mode   <= 1'b0;
      r_relu   <= 1'b0;
      r_bitsel <= 1'b0;
      r_b      <= '0;
      r_data   <= '0;
      r_bit    <= 1'b0;
      r_err    <= 1'b0;
      r_req    <= 1'b0;
      r_wen    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_rdy   <= 1'b1;
      r_req   <= w_req;
      r_wen   <= w_wen;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      if (w_cmd_fire) begin
        r_cnt    <= cmd_len_i;
        r_mode   <= cmd_mode_i;
        r_relu   <= cmd_relu_i;
        r_bitsel <= cmd_bitsel_i;
        r_data   <= '0;
        r_bit    <= 1'b0;
      end
      if (w_op_fire) begin
        r_b <= op_b_i;
      end
      // Count drops on each issued MAC and on each pair discarded after a timeout.
      if (((r_state == ST_WR_GO) || (w_op_fire && (r_state == ST_DRAIN))) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - LEN_W'(1);
      end
      if (r_state == ST_GAP) begin
        r_poll <= '0;
      end else if (r_state == ST_POLL) begin
        r_poll <= r_poll + PW'(1);
      end
      if ((r_state == ST_POLL) && !w_vld && w_poll_last) begin
        r_err <= 1'b1;
      end
      if (r_state == ST_RD_DAT) begin
        r_data <= rdata_i[23:0];
      end
      if (r_state == ST_RD_BIT) begin
        r_bit <= rdata_i[0];
      end
      if (w_res_fire) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_bus_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pe_bus_sequencer : PE slave model plus job-level reference for pe_bus_sequencer
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pe_bus_sequencer;

  localparam int POLL_MAX = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_mode_i, cmd_relu_i, cmd_bitsel_i;
  logic [7:0]  cmd_len_i;
  logic [23:0] cmd_thresh_i;
  logic        op_valid_i, op_ready_o;
  logic [7:0]  op_a_i, op_b_i;
  logic        res_valid_o, res_ready_i, res_bit_o, res_err_o, busy_o;
  logic [23:0] res_data_o;
  logic        req_o;
  logic [3:0]  wen_o;
  logic [2:0]  addr_o;
  logic [31:0] wdata_o, rdata_i;

  always #5 clk = ~clk;

  pe_bus_sequencer #(.ADDR_WIDTH(3), .LEN_W(8), .POLL_MAX(POLL_MAX)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
    .cmd_mode_i(cmd_mode_i), .cmd_relu_i(cmd_relu_i), .cmd_bitsel_i(cmd_bitsel_i),
    .cmd_thresh_i(cmd_thresh_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_bit_o(res_bit_o), .res_err_o(res_err_o), .busy_o(busy_o),
    .req_o(req_o), .wen_o(wen_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_word(input logic start, input logic clr, input logic mode,
                                            input logic relu, input logic bitsel);
    return {27'h0, bitsel, relu, clr, mode, start};
  endfunction

  // PE register-window slave: MAC on start, out_vld after a per-MAC latency.
  logic [7:0]  s_a = 8'h0, s_b = 8'h0;
  logic [23:0] s_thr = 24'h0;
  int          s_acc = 0;
  int          s_lat = 0;
  logic        s_relu = 1'b0, s_bitsel = 1'b0;
  bit          s_stuck = 1'b0;
  int          latq[$];
  int          s_res;
  logic        s_recog;
  logic [31:0] s_rdata;

  function automatic int pop_lat();
    if (latq.size() == 0) return 0;
    return latq.pop_front();
  endfunction

  always @(posedge clk) begin
    if (s_lat > 0) s_lat <= s_lat - 1;
    if (req_o && (wen_o != 4'h0)) begin
      case (addr_o)
        3'd0: s_a <= wdata_o[7:0];
        3'd1: s_b <= wdata_o[7:0];
        3'd3: s_thr <= wdata_o[23:0];
        3'd2: begin
          s_relu   <= wdata_o[3];
          s_bitsel <= wdata_o[4];
          if (wdata_o[2]) s_acc <= 0;
          else if (wdata_o[0]) begin
            s_acc <= s_acc + int'(s_a) * int'($signed(s_b));
            s_lat <= pop_lat();
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_res   = (s_relu && (s_acc < 0)) ? 0 : s_acc;
    s_recog = s_bitsel ? (s_res > int'($signed(s_thr))) : (s_res < int'($signed(s_thr)));
    s_rdata = 32'h0;
    case (addr_o)
      3'd2: s_rdata[8] = (s_lat == 0) && !s_stuck;
      3'd4: s_rdata = 32'(s_res);
      3'd5: s_rdata[0] = s_recog;
      default: ;
    endcase
  end
  assign rdata_i = s_rdata;

  // Bus monitor: status polls are counted, every other transfer is logged.
  logic [38:0] obs[$];
  int          n_polls = 0;
  initial forever begin
    @(negedge clk);
    if (req_o) begin
      if ((wen_o == 4'h0) && (addr_o == 3'd2)) n_polls++;
      else obs.push_back({wen_o, addr_o, (wen_o != 4'h0) ? wdata_o : 32'h0});
    end
  end

  // Operand source with optional random valid gaps.
  logic [7:0] pq_a[$], pq_b[$];
  bit         op_rand = 1'b0;
  bit         took = 1'b0;
  int         n_took = 0;
  initial begin
    op_valid_i = 1'b0; op_a_i = 8'h0; op_b_i = 8'h0;
    forever begin
      @(negedge clk);
      if (took && (pq_a.size() > 0)) begin
        pq_a.delete(0); pq_b.delete(0); n_took++;
      end
      took = 1'b0;
      if (pq_a.size() > 0) begin
        op_valid_i = op_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        op_a_i = pq_a[0];
        op_b_i = pq_b[0];
      end else begin
        op_valid_i = 1'b0;
      end
      #1;
      took = op_valid_i && op_ready_o;
    end
  end

  logic [7:0]  job_a[$], job_b[$];
  int          job_lat[$];
  logic [38:0] exp_q[$];
  logic [23:0] exp_data;
  logic        exp_bit, exp_err;
  int          exp_polls, exp_n;

  task automatic rand_pairs(input int n);
    job_a.delete(); job_b.delete(); job_lat.delete();
    for (int i = 0; i < n; i++) begin
      job_a.push_back(8'($urandom_range(0, 255)));
      job_b.push_back(8'($urandom_range(0, 255)));
      job_lat.push_back(int'($urandom_range(0, 4)));
    end
  endtask

  task automatic start_job(input bit mode, input bit relu, input bit bitsel, input int thresh,
                           input bit stuck, input bit orand);
    int sum, n, mac_n, c;
    logic [23:0] t24;
    n = job_a.size();
    t24 = 24'(thresh);
    sum = 0;
    for (int i = 0; i < n; i++) sum += int'(job_a[i]) * int'($signed(job_b[i]));
    if (relu && (sum < 0)) sum = 0;
    exp_err  = stuck && (n > 0);
    exp_data = exp_err ? 24'h0 : sum[23:0];
    exp_bit  = exp_err ? 1'b0 : (bitsel ? (sum > thresh) : (sum < thresh));
    exp_n    = n;
    exp_polls = 0;
    exp_q.delete();
    exp_q.push_back({4'b0111, 3'd3, 8'h00, t24});
    exp_q.push_back({4'b0001, 3'd2, ctrl_word(1'b0, 1'b1, mode, relu, bitsel)});
    mac_n = exp_err ? 1 : n;
    for (int i = 0; i < mac_n; i++) begin
      exp_q.push_back({4'b0001, 3'd0, 24'h0, job_a[i]});
      exp_q.push_back({4'b0001, 3'd1, 24'h0, job_b[i]});
      exp_q.push_back({4'b0001, 3'd2, ctrl_word(1'b1, 1'b0, mode, relu, bitsel)});
      exp_polls += exp_err ? POLL_MAX : ((job_lat[i] == 0) ? 1 : job_lat[i]);
    end
    if (!exp_err) begin
      exp_q.push_back({4'b0000, 3'd4, 32'h0});
      exp_q.push_back({4'b0000, 3'd5, 32'h0});
    end
    obs.delete(); n_polls = 0; n_took = 0;
    latq = job_lat; s_stuck = stuck; op_rand = orand;
    pq_a = job_a; pq_b = job_b;
    cmd_len_i = 8'(n); cmd_mode_i = mode; cmd_relu_i = relu; cmd_bitsel_i = bitsel;
    cmd_thresh_i = t24; cmd_valid_i = 1'b1;
    c = 0;
    while (!cmd_ready_o && (c < 100)) begin @(negedge clk); c++; end
    chk("cmd_accept", 64'(cmd_ready_o), 64'(1));
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic finish_job(input int hold);
    int c;
    c = 0;
    while (!res_valid_o && (c < 20000)) begin @(negedge clk); c++; end
    chk("res_valid", 64'(res_valid_o), 64'(1));
    chk("res_data", 64'(res_data_o), 64'(exp_data));
    chk("res_bit", 64'(res_bit_o), 64'(exp_bit));
    chk("res_err", 64'(res_err_o), 64'(exp_err));
    chk("busy_resp", 64'(busy_o), 64'(1));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("res_hold", 64'({res_valid_o, res_data_o, res_bit_o, res_err_o}),
          64'({1'b1, exp_data, exp_bit, exp_err}));
    end
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    chk("after_resp", 64'({res_valid_o, cmd_ready_o, res_err_o, busy_o}), 64'(4'b0100));
    chk("pairs_used", 64'(n_took), 64'(exp_n));
    chk("poll_count", 64'(n_polls), 64'(exp_polls));
    chk("bus_count", 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; (i < obs.size()) && (i < exp_q.size()); i++)
      chk("bus_txn", 64'(obs[i]), 64'(exp_q[i]));
  endtask

  task automatic run_job(input bit mode, input bit relu, input bit bitsel, input int thresh,
                         input bit stuck, input bit orand, input int hold);
    start_job(mode, relu, bitsel, thresh, stuck, orand);
    finish_job(hold);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_bus"}, 64'({req_o, wen_o, addr_o, wdata_o}), 64'(0));
    chk({tag, "_ctl"}, 64'({cmd_ready_o, op_ready_o, res_valid_o, res_data_o, res_bit_o,
                             res_err_o, busy_o}), 64'(0));
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    cmd_valid_i = 1'b0; cmd_len_i = 8'h0; cmd_mode_i = 1'b0; cmd_relu_i = 1'b0;
    cmd_bitsel_i = 1'b0; cmd_thresh_i = 24'h0; res_ready_i = 1'b0;
    #12;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", 64'(cmd_ready_o), 64'(1));

    job_a = '{8'd1, 8'd2, 8'd3};
    job_b = '{8'd4, 8'd5, 8'hFA};
    job_lat = '{0, 1, 3};
    run_job(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    job_lat = '{2, 0, 1};
    run_job(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    job_lat = '{1, 1, 4};
    run_job(1'b1, 1'b0, 1'b1, -20, 1'b0, 1'b0, 0);

    rand_pairs(0);
    run_job(1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0, 2);

    rand_pairs(2);
    run_job(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
    rand_pairs(3);
    run_job(1'b0, 1'b0, 1'b1, 100, 1'b0, 1'b0, 0);

    rand_pairs(5);
    run_job(1'b1, 1'b0, 1'b0, -300, 1'b0, 1'b1, 10);

    rand_pairs(2);
    start_job(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    c = 0;
    while ((n_polls < 5) && (c < 500)) begin @(negedge clk); c++; end
    chk("poll_reached", 64'(n_polls >= 5), 64'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_reset");
    pq_a.delete(); pq_b.delete(); took = 1'b0; s_stuck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_mid_reset", 64'(cmd_ready_o), 64'(1));
    rand_pairs(3);
    run_job(1'b0, 1'b1, 1'b1, 50, 1'b0, 1'b1, 3);

    for (int j = 0; j < 10; j++) begin
      rand_pairs(int'($urandom_range(0, 5)));
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2000)) - 1000, 1'b0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 10)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
